// File: rtl/digit_scan_if.sv
// Bus between the BCD datapath and the 4-digit display scan controller.
// The datapath side drives the i_* signals, and the scan controller drives the o_* pins.
interface digit_scan_if;
  logic        i_en;
  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic        i_lz_en;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_done;

  modport master (
    output i_en, i_bcd, i_dp, i_lz_en,
    input  o_an, o_seg, o_dp, o_frame_done
  );

  modport slave (
    input  i_en, i_bcd, i_dp, i_lz_en,
    output o_an, o_seg, o_dp, o_frame_done
  );
endinterface

// File: rtl/digit_scan_controller.sv
// Single-clock, enable-based scanner for a 4-digit common-anode 7-segment display.
// Each digit slot has a blank gap followed by a lit phase. Inputs are latched once per frame.
module digit_scan_controller #(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input logic         i_clk,
  input logic         i_reset,
  digit_scan_if.slave bus
);

  localparam int CW = $clog2(DIGIT_CYCLES);

  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_SHOW  = 1'b1;

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   lat_bcd;
  logic [3:0]    lat_dp;
  logic          lat_lz;

  logic [0:0]    phase;
  logic          cnt_last;
  logic [3:0]    nibble;
  logic [3:0]    lz_blank;
  logic          lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so that no path can infer a latch.
  always_comb begin
    phase    = (cnt < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    cnt_last = (cnt == CW'(DIGIT_CYCLES - 1));
    nibble   = lat_bcd[{dig, 2'b00} +: 4];
    // A digit is blanked only while it and every digit above it are zero.
    lz_blank    = 4'b0000;
    lz_blank[3] = lat_lz && (lat_bcd[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (lat_bcd[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (lat_bcd[7:4] == 4'd0);
    lit = (phase == PH_SHOW) && !lz_blank[dig];
  end

  // NOTE: sequential state uses non-blocking assignments so that all registers update together on the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset || !bus.i_en) begin
      cnt              <= '0;
      dig              <= 2'd0;
      bus.o_an         <= 4'b1111;
      bus.o_seg        <= 7'b1111111;
      bus.o_dp         <= 1'b1;
      bus.o_frame_done <= 1'b0;
      // NOTE: the frame latch is cleared only by reset. Disabling the scan leaves its contents intact.
      if (i_reset) begin
        lat_bcd <= '0;
        lat_dp  <= '0;
        lat_lz  <= 1'b0;
      end
    end else begin
      if (cnt == '0 && dig == 2'd0) begin
        lat_bcd <= bus.i_bcd;
        lat_dp  <= bus.i_dp;
        lat_lz  <= bus.i_lz_en;
      end

      bus.o_an         <= lit ? ~(4'b0001 << dig) : 4'b1111;
      bus.o_seg        <= lit ? seg_decode(nibble) : 7'b1111111;
      bus.o_dp         <= lit ? ~lat_dp[dig] : 1'b1;
      bus.o_frame_done <= cnt_last && (dig == 2'd3);

      if (cnt_last) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/digit_scan_controller.md
Name: digit_scan_controller

Overview:
- Time-multiplexes a 4-digit common-anode 7-segment display from one system clock.
- Replaces the free-running derived-clock scan with a single-clock, enable-based sequencer.
- Each digit slot has two phases: an anti-ghosting blank gap, then the digit is driven.
- Inputs are captured once per frame, so a digit value never changes while it is displayed.
- Sits between the counter/BCD datapath and the board anode/segment pins.

Parameters:
- DIGIT_CYCLES, 100_000: i_clk cycles per digit slot (1 kHz slot rate at 100 MHz). Legal range ≥ 2.
- BLANK_CYCLES, 1_000: cycles at the start of each slot with all anodes off. Legal range 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_en  input  1  scan enable; low = display dark and sequencer parked
- i_bcd  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- i_dp  input  4  decimal-point request per digit; bit n = digit n, active-high
- i_lz_en  input  1  leading-zero blanking enable
- o_an  output  4  anode selects, active-low; bit n = digit n
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- o_dp  output  1  decimal point, active-low
- o_frame_done  output  1  one-cycle pulse at the end of digit 3's slot

Behaviour:
- Reset: synchronous on an i_clk edge with i_reset=1. Values after reset:
  - o_an=4'b1111, o_seg=7'b1111111, o_dp=1, o_frame_done=0
  - slot counter=0, digit index=0, phase=BLANK
  - frame latch cleared to 0
  - Reset mid-frame behaves identically.
- State:
  - Slot counter cnt runs 0..DIGIT_CYCLES-1 and wraps.
  - Phase = BLANK while cnt < BLANK_CYCLES, otherwise SHOW.
  - Digit index advances 0→1→2→3→0 on each cnt wrap.
- Frame latch: i_bcd, i_dp and i_lz_en are captured on the cycle cnt=0 with digit index=0. Outside that cycle, input changes have no visible effect until the next frame.
- Outputs are registered: each output reflects the counter/phase state one cycle after it is reached.
  - During BLANK: o_an=4'b1111, o_seg=7'b1111111, o_dp=1.
  - During SHOW: the anode bit for the current digit is 0 and all others are 1. o_seg/o_dp come from the latched nibble and dp bit.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles A–F display a dash: 0111111.
- Leading-zero blanking (latched i_lz_en=1):
  - Digit n, for n = 3 down to 1, is blank when it and every higher digit are 0. Blank means its anode stays 1 for the whole slot.
  - Digit 0 is never blanked.
  - A blanked digit's dp is suppressed. A nonzero or invalid nibble stops blanking.
- o_frame_done: asserted for exactly one cycle, in the same cycle the outputs reflect the last SHOW cycle of digit 3.
- i_en=0: on the next edge, outputs take their reset values and cnt, digit index and phase return to 0 / 0 / BLANK. The latch holds its contents.
- i_en rising: scanning restarts at digit 0 BLANK with a fresh latch capture.
- i_reset and i_en=0 together: reset dominates, with the same result.
- Timing:
  - Frame period = 4*DIGIT_CYCLES.
  - Each digit has exactly DIGIT_CYCLES-BLANK_CYCLES active cycles per frame.
  - No two anodes are ever low in the same cycle.

Test Plan:
- Reset release, DIGIT_CYCLES=10, BLANK_CYCLES=2, i_en=1, i_bcd=16'h1234 → o_an=1111 through edge 2. At edge 3, o_an=1110 with o_seg=0011001 ("4"), held 8 cycles. Digits 1/2/3 then show "3"/"2"/"1". o_frame_done pulses once per 40 cycles.
- i_bcd changed 16'h1234→16'h5678 mid-frame at digit 1 → the rest of that frame still shows 1234. The next frame shows 5678.
- i_lz_en=1, i_bcd=16'h0050 → digits 3 and 2 anodes never low. Digit 1 shows "5" and digit 0 shows "0". i_bcd=16'h0000 → only digit 0 lit, showing "0".
- i_bcd=16'h00F0, i_dp=4'b0100, i_lz_en=0 → digit 1 shows dash 0111111. o_dp=0 only during digit 2's SHOW phase.
- i_en dropped during digit 2's SHOW → next cycle o_an=1111. On re-enable, digit 0 BLANK restarts at cnt=0 and the new i_bcd is captured.
- i_reset pulsed for 1 cycle during digit 3's SHOW → all outputs return to reset values the next cycle. No o_frame_done pulse is emitted, and scanning restarts from digit 0.
